// File: rtl/start_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : start_rr_scheduler
// Description : Round-robin scheduler in front of one shared, fixed-latency,
//               start-triggered engine. Grants one requester at a time,
//               pulses the engine start with the requester ID, and returns
//               a one-hot done pulse to that requester exactly LATENCY
//               cycles after its start by carrying the ID down a tag pipe.
// Ports       : aclk, aresetn (async, active-low)
//               iEnable   - allows new grants (in-flight ops always finish)
//               iReq      - per-requester level request
//               oAck      - one-hot grant, high only in the start cycle
//               oStart    - single-cycle engine start pulse
//               oStartId  - granted ID while oStart=1, else 0
//               oDone     - one-hot done pulse, LATENCY cycles after start
//               oInFlight - started but not yet done operations
//               oIdle     - no arbitration activity and nothing in flight
// Options     : `define START_RR_SCHED_CHECK_EN adds iEngDone (engine
//               result-valid) and sticky oLatErr, set whenever iEngDone
//               disagrees with the retiring tag.
// Revision    : 1.0 - initial release
// ============================================================================
module start_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 5,
  parameter int MIN_GAP = 0
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         iEnable,
  input  logic [NUM_REQ-1:0]           iReq,
`ifdef START_RR_SCHED_CHECK_EN
  input  logic                         iEngDone,
  output logic                         oLatErr,
`endif
  output logic [NUM_REQ-1:0]           oAck,
  output logic                         oStart,
  output logic [$clog2(NUM_REQ)-1:0]   oStartId,
  output logic [NUM_REQ-1:0]           oDone,
  output logic [$clog2(LATENCY+1)-1:0] oInFlight,
  output logic                         oIdle
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(LATENCY+1);
  localparam int GAPW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   idx;
  logic             found;
  logic             grant;
  logic [GAPW-1:0]  gap_cnt, gap_nxt;
  logic             tag_vld [LATENCY];
  logic [IDW-1:0]   tag_id  [LATENCY];
  logic [NUM_REQ-1:0] done_nxt;
  logic [CNTW-1:0]  inflight_nxt;

  // Round-robin search: first set request starting just above the last winner.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NUM_REQ);
      if (!found && iReq[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Next-state logic. The grant decision is taken in IDLE so that oStart and
  // oAck are registered and appear in the following (ISSUE) cycle.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    grant     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iEnable && found) begin
          grant     = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (MIN_GAP > 0) begin
          state_nxt = ST_GAP;
          gap_nxt   = GAPW'(MIN_GAP);
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        gap_nxt = gap_cnt - GAPW'(1);
        if (gap_cnt <= GAPW'(1)) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Start and done in the same cycle leave the count unchanged.
  always_comb begin
    inflight_nxt = oInFlight;
    if (oStart && !(|oDone)) begin
      inflight_nxt = oInFlight + CNTW'(1);
    end else if (!oStart && (|oDone)) begin
      inflight_nxt = oInFlight - CNTW'(1);
    end
  end

  // Tag pipe: stage 0 is loaded together with the registered start, so the
  // last stage is valid in cycle start+LATENCY-1 and the registered oDone
  // lands exactly LATENCY cycles after oStart.
  for (genvar s = 0; s < LATENCY; s++) begin : g_tag
    logic           vld_d;
    logic [IDW-1:0] id_d;
    if (s == 0) begin : g_head
      assign vld_d = grant;
      assign id_d  = winner;
    end else begin : g_body
      assign vld_d = tag_vld[s-1];
      assign id_d  = tag_id[s-1];
    end
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        tag_vld[s] <= 1'b0;
        tag_id[s]  <= '0;
      end else begin
        tag_vld[s] <= vld_d;
        tag_id[s]  <= id_d;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_done
    assign done_nxt[g] = tag_vld[LATENCY-1] && (tag_id[LATENCY-1] == IDW'(g));
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      ptr       <= IDW'(NUM_REQ-1);
      gap_cnt   <= '0;
      oAck      <= '0;
      oStart    <= 1'b0;
      oStartId  <= '0;
      oDone     <= '0;
      oInFlight <= '0;
      oIdle     <= 1'b1;
    end else begin
      state     <= state_nxt;
      gap_cnt   <= gap_nxt;
      oStart    <= grant;
      oAck      <= grant ? (NUM_REQ'(1) << winner) : '0;
      oStartId  <= grant ? winner : '0;
      if (grant) begin
        ptr <= winner;
      end
      oDone     <= done_nxt;
      oInFlight <= inflight_nxt;
      oIdle     <= (state_nxt == ST_IDLE) && (inflight_nxt == '0);
    end
  end

`ifdef START_RR_SCHED_CHECK_EN
  // oDone is the registered image of the retiring tag, i.e. the cycle in
  // which the engine result is due.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      oLatErr <= 1'b0;
    end else if (iEngDone != (|oDone)) begin
      oLatErr <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire
